// File: rtl/y86_mc_pkg.sv
// Shared types and constants for the multi-cycle y86-subset core.
// Holds the FSM state encoding, the opcode map and the instruction-length decoder.
package y86_mc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_HALT
    } state_t;

    localparam logic [7:0] OP_LOAD = 8'h8B;
    localparam logic [7:0] OP_MOV  = 8'h89;
    localparam logic [7:0] OP_ADD  = 8'h01;
    localparam logic [7:0] OP_SUB  = 8'h29;
    localparam logic [7:0] OP_JNEZ = 8'h75;
    localparam logic [7:0] OP_JZ   = 8'h74;
    localparam logic [7:0] OP_NOP  = 8'h90;
    localparam logic [7:0] OP_HALT = 8'hF4;

    localparam logic [1:0] MOD_MEM  = 2'd1;
    localparam logic [1:0] MOD_REG  = 2'd3;
    localparam logic [2:0] BASE_REG = 3'd6;
    localparam int         NREGS    = 8;

    // 0x89/0x8B are three bytes with a displacement (mod=1), two bytes otherwise.
    function automatic logic [1:0] instr_len(input logic [7:0] op, input logic [1:0] md);
        case (op)
            OP_LOAD, OP_MOV:                instr_len = (md == MOD_MEM) ? 2'd3 : 2'd2;
            OP_ADD, OP_SUB, OP_JNEZ, OP_JZ: instr_len = 2'd2;
            default:                        instr_len = 2'd1;
        endcase
    endfunction

endpackage

// File: rtl/y86_mc_regfile.sv
// Eight-entry general register file: two asynchronous read ports, one
// synchronous write port, all entries cleared by the asynchronous reset.
module y86_mc_regfile
    import y86_mc_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic [2:0]    i_ra_addr,
    output logic [DW-1:0] o_ra_data,
    input  logic [2:0]    i_rb_addr,
    output logic [DW-1:0] o_rb_data,
    input  logic          i_we,
    input  logic [2:0]    i_wa_addr,
    input  logic [DW-1:0] i_wa_data
);

    logic [DW-1:0] r_regs [0:NREGS-1];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we) begin
            r_regs[i_wa_addr] <= i_wa_data;
        end
    end

    assign o_ra_data = r_regs[i_ra_addr];
    assign o_rb_data = r_regs[i_rb_addr];

endmodule

// File: rtl/y86_mc_core.sv
// Multi-cycle y86-subset core on a single shared memory bus with a ready
// handshake; stops in HALT on F4 or on an undefined opcode.
module y86_mc_core
    import y86_mc_pkg::*;
#(
    parameter int            DW       = 32,
    parameter int            AW       = 32,
    parameter logic [DW-1:0] RESET_IP = '0
) (
    input  logic          clk,
    input  logic          rst,
    output logic [AW-1:0] bus_A,
    input  logic [DW-1:0] bus_in,
    output logic [DW-1:0] bus_out,
    output logic          bus_RE,
    output logic          bus_WE,
    input  logic          bus_ready,
    output logic [7:0]    current_opcode,
    output logic          halted,
    output logic          illegal
);

    state_t        r_state, w_next_state;
    logic [DW-1:0] r_ip, r_a, r_b, r_c, r_mar, r_mdr;
    logic [23:0]   r_ir;
    logic          r_zf, r_halted, r_illegal;

    logic [7:0]    w_op;
    logic [1:0]    w_mod;
    logic [2:0]    w_rs, w_rd;
    logic          w_load, w_store, w_mov, w_add, w_sub, w_jnez, w_jz, w_nop, w_halt;
    logic          w_mem, w_legal, w_taken, w_rf_we;
    logic [DW-1:0] w_disp, w_dist, w_next_ip, w_alu, w_rf_a, w_rf_b;

    assign w_op  = r_ir[7:0];
    assign w_mod = r_ir[15:14];
    assign w_rs  = r_ir[13:11];
    assign w_rd  = r_ir[10:8];

    assign w_load  = (w_op == OP_LOAD) && (w_mod == MOD_MEM);
    assign w_store = (w_op == OP_MOV)  && (w_mod == MOD_MEM);
    assign w_mov   = (w_op == OP_MOV)  && (w_mod == MOD_REG);
    assign w_add   = (w_op == OP_ADD);
    assign w_sub   = (w_op == OP_SUB);
    assign w_jnez  = (w_op == OP_JNEZ);
    assign w_jz    = (w_op == OP_JZ);
    assign w_nop   = (w_op == OP_NOP);
    assign w_halt  = (w_op == OP_HALT);
    assign w_mem   = w_load || w_store;
    assign w_legal = w_mem || w_mov || w_add || w_sub || w_jnez || w_jz || w_nop || w_halt;

    assign w_disp    = {{(DW-8){r_ir[23]}}, r_ir[23:16]};
    assign w_dist    = {{(DW-8){r_ir[15]}}, r_ir[15:8]};
    assign w_taken   = (w_jnez && !r_zf) || (w_jz && r_zf);
    assign w_next_ip = r_ip + DW'(instr_len(w_op, w_mod)) + (w_taken ? w_dist : '0);

    always_comb begin
        w_alu = r_b;
        if (w_add) begin
            w_alu = r_a + r_b;
        end else if (w_sub) begin
            w_alu = r_a - r_b;
        end
    end

    // Memory ops address through the base register; loads write back into RS.
    assign w_rf_we = (r_state == ST_WB) && (w_load || w_add || w_sub || w_mov);

    y86_mc_regfile #(.DW(DW)) u_regfile (
        .i_clk     (clk),
        .i_rst_n   (rst),
        .i_ra_addr (w_mem ? BASE_REG : w_rd),
        .o_ra_data (w_rf_a),
        .i_rb_addr (w_rs),
        .o_rb_data (w_rf_b),
        .i_we      (w_rf_we),
        .i_wa_addr (w_load ? w_rs : w_rd),
        .i_wa_data (w_load ? r_mdr : r_c)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        bus_RE       = 1'b0;
        bus_WE       = 1'b0;
        bus_A        = '0;
        case (r_state)
            ST_IDLE:   w_next_state = ST_FETCH;
            ST_FETCH: begin
                bus_RE = 1'b1;
                bus_A  = r_ip[AW-1:0];
                if (bus_ready) w_next_state = ST_DECODE;
            end
            ST_DECODE: w_next_state = (w_halt || !w_legal) ? ST_HALT : ST_EXEC;
            ST_EXEC:   w_next_state = w_mem ? ST_MEM : ST_WB;
            ST_MEM: begin
                bus_RE = w_load;
                bus_WE = w_store;
                bus_A  = r_mar[AW-1:0];
                if (bus_ready) w_next_state = ST_WB;
            end
            ST_WB:     w_next_state = ST_FETCH;
            ST_HALT:   w_next_state = ST_HALT;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ip      <= RESET_IP;
            r_ir      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_c       <= '0;
            r_mar     <= '0;
            r_mdr     <= '0;
            r_zf      <= 1'b0;
            r_halted  <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (bus_ready) r_ir <= bus_in[23:0];
                end
                ST_DECODE: begin
                    // A stopping instruction leaves IP on its own address.
                    if (w_halt || !w_legal) begin
                        r_halted  <= 1'b1;
                        r_illegal <= !w_legal;
                    end else begin
                        r_a  <= w_rf_a;
                        r_b  <= w_rf_b;
                        r_ip <= w_next_ip;
                    end
                end
                ST_EXEC: begin
                    if (w_mem) r_mar <= r_a + w_disp;
                    r_c <= w_alu;
                    if (w_add || w_sub) r_zf <= (w_alu == '0);
                end
                ST_MEM: begin
                    if (bus_ready && w_load) r_mdr <= bus_in;
                end
                default: ;
            endcase
        end
    end

    assign bus_out        = r_b;
    assign current_opcode = r_ir[7:0];
    assign halted         = r_halted;
    assign illegal        = r_illegal;

endmodule

// File: tb/tb_y86_mc_core.sv
// Directed bench for y86_mc_core: byte memory model with controllable ready
// and an in-order scoreboard of expected bus transactions.
module tb_y86_mc_core;

    localparam int          DW  = 32;
    localparam int          AW  = 32;
    localparam logic [31:0] RIP = 32'h100;

    logic          clk;
    logic          rst;
    logic [AW-1:0] bus_A;
    logic [DW-1:0] bus_in;
    logic [DW-1:0] bus_out;
    logic          bus_RE;
    logic          bus_WE;
    logic          bus_ready;
    logic [7:0]    current_opcode;
    logic          halted;
    logic          illegal;

    logic [7:0] mem [0:511];

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    txn_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   n_strobe = 0;
    int   n_we     = 0;

    y86_mc_core #(.DW(DW), .AW(AW), .RESET_IP(RIP)) dut (
        .clk            (clk),
        .rst            (rst),
        .bus_A          (bus_A),
        .bus_in         (bus_in),
        .bus_out        (bus_out),
        .bus_RE         (bus_RE),
        .bus_WE         (bus_WE),
        .bus_ready      (bus_ready),
        .current_opcode (current_opcode),
        .halted         (halted),
        .illegal        (illegal)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign bus_in = {mem[9'(bus_A + 32'd3)], mem[9'(bus_A + 32'd2)],
                     mem[9'(bus_A + 32'd1)], mem[9'(bus_A)]};

    task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic we, input logic [31:0] addr, input logic [31:0] data);
        txn_t t;
        t.we   = we;
        t.addr = addr;
        t.data = data;
        exp_q.push_back(t);
    endtask

    // Any transaction that will complete on the coming edge is matched in order.
    task automatic tick();
        txn_t obs;
        txn_t e;
        #1;
        if ((bus_RE || bus_WE) && bus_ready) begin
            obs.we   = bus_WE;
            obs.addr = bus_A;
            obs.data = bus_WE ? bus_out : 32'h0;
            chk("sb_expected", 65'(exp_q.size() != 0), 65'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("sb_txn", 65'(obs), 65'(e));
            end
        end
        if (bus_RE || bus_WE) n_strobe++;
        if (bus_WE) n_we++;
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic chk_fetch(input string tag, input logic [31:0] addr);
        chk(tag, {32'h0, bus_WE, bus_RE, bus_A[30:0]}, {32'h0, 1'b0, 1'b1, addr[30:0]});
    endtask

    initial begin
        rst       = 1'b0;
        bus_ready = 1'b1;
        for (int i = 0; i < 512; i++) mem[i] = 8'h00;
        mem[4] = 8'h05;
        {mem[9'h100], mem[9'h101], mem[9'h102]} = {8'h8B, 8'h4E, 8'h04};
        {mem[9'h103], mem[9'h104]}              = {8'h01, 8'hC8};
        {mem[9'h105], mem[9'h106], mem[9'h107]} = {8'h89, 8'h46, 8'h08};
        {mem[9'h108], mem[9'h109]}              = {8'h29, 8'hC0};
        {mem[9'h10A], mem[9'h10B]}              = {8'h75, 8'hFE};
        {mem[9'h10C], mem[9'h10D]}              = {8'h89, 8'hCA};
        {mem[9'h10E], mem[9'h10F], mem[9'h110]} = {8'h89, 8'h56, 8'h0C};
        {mem[9'h111], mem[9'h112], mem[9'h113]} = {8'h74, 8'hFE, 8'hF4};

        ticks(3);
        chk("rst_strobes", 65'({bus_RE, bus_WE}), 65'd0);
        chk("rst_bus_A", 65'(bus_A), 65'd0);
        chk("rst_bus_out", 65'(bus_out), 65'd0);
        chk("rst_status", 65'({current_opcode, halted, illegal}), 65'd0);

        rst = 1'b1;
        #1;
        chk("idle_cycle1_RE", 65'(bus_RE), 65'd0);
        push(1'b0, 32'h100, 0); push(1'b0, 32'h004, 0);
        push(1'b0, 32'h103, 0); push(1'b0, 32'h105, 0);
        push(1'b1, 32'h008, 5); push(1'b0, 32'h108, 0);
        push(1'b0, 32'h10A, 0); push(1'b0, 32'h10C, 0);
        push(1'b0, 32'h10E, 0); push(1'b1, 32'h00C, 5);
        push(1'b0, 32'h111, 0); push(1'b0, 32'h111, 0);
        tick();
        chk_fetch("first_fetch", RIP);

        ticks(5);
        chk_fetch("fetch_after_load", 32'h103);
        ticks(4);
        chk_fetch("fetch_after_add", 32'h105);
        chk("zf_after_add", 65'(dut.r_zf), 65'd0);
        n_we = 0;
        ticks(3);
        chk("store_mem_bus", {bus_RE, bus_WE, bus_A, bus_out}, {1'b0, 1'b1, 32'h8, 32'h5});
        tick();
        chk("store_wb_WE", 65'(bus_WE), 65'd0);
        tick();
        chk_fetch("fetch_after_store", 32'h108);
        chk("store_we_cycles", 65'(n_we), 65'd1);
        ticks(4);
        chk_fetch("fetch_after_sub", 32'h10A);
        chk("zf_after_sub", 65'(dut.r_zf), 65'd1);
        ticks(4);
        chk_fetch("jnez_not_taken", 32'h10C);
        ticks(4);
        chk_fetch("fetch_after_mov", 32'h10E);
        ticks(5);
        chk_fetch("fetch_jz", 32'h111);
        ticks(4);
        chk_fetch("jz_loop1", 32'h111);
        ticks(4);
        chk_fetch("jz_loop2", 32'h111);
        chk("sb_drained_main", 65'(exp_q.size()), 65'd0);

        mem[9'h112] = 8'h00;
        push(1'b0, 32'h111, 0); push(1'b0, 32'h113, 0);
        ticks(4);
        chk_fetch("fetch_halt", 32'h113);
        tick();
        chk("halt_in_decode", 65'(halted), 65'd0);
        tick();
        chk("halt_status", 65'({current_opcode, halted, illegal}), 65'({8'hF4, 1'b1, 1'b0}));
        chk("halt_ip", 65'(dut.r_ip), 65'h113);
        n_strobe = 0;
        ticks(5);
        chk("halt_no_strobes", 65'(n_strobe), 65'd0);
        chk("sb_drained_halt", 65'(exp_q.size()), 65'd0);

        rst = 1'b0;
        mem[9'h112] = 8'hFE;
        ticks(2);
        chk("rst_clears_halt", 65'({halted, illegal}), 65'd0);
        rst = 1'b1;
        tick();
        chk_fetch("ws_first_fetch", RIP);
        push(1'b0, 32'h100, 0); push(1'b0, 32'h004, 0);
        bus_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk_fetch("ws_fetch_held", RIP);
            tick();
        end
        bus_ready = 1'b1;
        chk_fetch("ws_fetch_4th", RIP);
        tick();
        chk("ws_ir_captured", 65'(current_opcode), 65'h8B);
        ticks(4);
        chk_fetch("ws_fetch_after_load", 32'h103);

        push(1'b0, 32'h103, 0); push(1'b0, 32'h105, 0);
        ticks(4);
        chk_fetch("ws_fetch_store", 32'h105);
        tick();
        bus_ready = 1'b0;
        ticks(2);
        chk("ws_store_mem", {bus_RE, bus_WE, bus_A, bus_out}, {1'b0, 1'b1, 32'h8, 32'h5});
        tick();
        chk("ws_store_stable", {bus_RE, bus_WE, bus_A, bus_out}, {1'b0, 1'b1, 32'h8, 32'h5});
        rst = 1'b0;
        #1;
        chk("rst_mid_mem_WE", 65'({bus_WE, bus_A}), 65'd0);
        chk("rst_regs_cleared", 65'({dut.u_regfile.r_regs[0], dut.u_regfile.r_regs[1]}), 65'd0);
        bus_ready = 1'b1;
        ticks(2);
        rst = 1'b1;
        tick();
        chk_fetch("restart_fetch", RIP);
        chk("sb_drained_ws", 65'(exp_q.size()), 65'd0);

        rst = 1'b0;
        mem[9'h100] = 8'hFF;
        tick();
        rst = 1'b1;
        push(1'b0, 32'h100, 0);
        tick();
        chk_fetch("illegal_fetch", RIP);
        tick();
        chk("illegal_in_decode", 65'(halted), 65'd0);
        tick();
        chk("illegal_status", 65'({current_opcode, halted, illegal}), 65'({8'hFF, 1'b1, 1'b1}));
        chk("illegal_ip", 65'(dut.r_ip), 65'h100);
        n_strobe = 0;
        ticks(4);
        chk("illegal_no_strobes", 65'(n_strobe), 65'd0);
        chk("sb_drained_end", 65'(exp_q.size()), 65'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
